// File: rtl/register_bank_ba.sv
// General-purpose register bank with base-address zeroing of register 0
// and a per-register pending scoreboard for outstanding multi-cycle loads.
module register_bank_ba #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned SEL_W      = 4,
  parameter int unsigned R0_BA_GATE = 1
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             wr_en,
  input  logic [SEL_W-1:0] wr_sel,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic             rd_en,
  input  logic [SEL_W-1:0] rd_sel,
  input  logic             BAout,
  input  logic             rsv_en,
  input  logic [SEL_W-1:0] rsv_sel,
  output logic [WIDTH-1:0] BusMuxIn,
  output logic             rd_stall,
  output logic [SEL_W:0]   pend_cnt,
  output logic             rsv_err
);

  localparam int unsigned CW = SEL_W + 1;

  logic [WIDTH-1:0]    regs [NUM_REGS];
  logic [NUM_REGS-1:0] valid;
  logic [NUM_REGS-1:0] valid_nxt;
  logic [CW-1:0]       cnt_nxt;
  logic                err_nxt;

  logic [WIDTH-1:0]    sel_data;
  logic                sel_valid;
  logic                sel_hit;
  logic                ba_zero;

  // Next scoreboard state: write sets valid, reserve clears it and wins on a tie.
  always_comb begin
    valid_nxt = valid;
    err_nxt   = rsv_err;
    cnt_nxt   = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_en && (wr_sel == SEL_W'(i))) valid_nxt[i] = 1'b1;
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rsv_en && (rsv_sel == SEL_W'(i))) begin
        valid_nxt[i] = 1'b0;
        if (!valid[i]) err_nxt = 1'b1;
      end
    end
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!valid_nxt[i]) cnt_nxt = cnt_nxt + CW'(1);
    end
  end

  // All state updates on the falling edge; clear discards everything at once.
  always_ff @(negedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      valid    <= '1;
      pend_cnt <= '0;
      rsv_err  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_en && (wr_sel == SEL_W'(i))) regs[i] <= BusMuxOut;
      end
      valid    <= valid_nxt;
      pend_cnt <= cnt_nxt;
      rsv_err  <= err_nxt;
    end
  end

  // Read select; out-of-range selects never hit.
  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b1;
    sel_hit   = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rd_sel == SEL_W'(i)) begin
        sel_hit   = 1'b1;
        sel_data  = regs[i];
        sel_valid = valid[i];
      end
    end
  end

  assign ba_zero  = (R0_BA_GATE != 0) && BAout && (rd_sel == '0);
  assign rd_stall = clear && rd_en && sel_hit && !sel_valid && !ba_zero;
  assign BusMuxIn = (clear && rd_en && sel_hit && sel_valid && !ba_zero) ? sel_data : '0;

endmodule

// File: tb/tb_register_bank_ba.sv
// Directed bench for register_bank_ba: default bank, ungated-R0 bank and 12-entry bank.
module tb_register_bank_ba;

  logic        clock;
  logic        clear;
  logic        wr_en, rd_en, BAout, rsv_en;
  logic [3:0]  wr_sel, rd_sel, rsv_sel;
  logic [31:0] BusMuxOut;

  logic [31:0] data_m, data_n, data_12;
  logic        stall_m, stall_n, stall_12;
  logic [4:0]  cnt_m, cnt_n, cnt_12;
  logic        err_m, err_n, err_12;

  int checks   = 0;
  int failures = 0;

  register_bank_ba u_dut (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_sel(wr_sel), .BusMuxOut(BusMuxOut),
    .rd_en(rd_en), .rd_sel(rd_sel), .BAout(BAout), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .BusMuxIn(data_m), .rd_stall(stall_m), .pend_cnt(cnt_m), .rsv_err(err_m));

  register_bank_ba #(.R0_BA_GATE(0)) u_nog (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_sel(wr_sel), .BusMuxOut(BusMuxOut),
    .rd_en(rd_en), .rd_sel(rd_sel), .BAout(BAout), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .BusMuxIn(data_n), .rd_stall(stall_n), .pend_cnt(cnt_n), .rsv_err(err_n));

  register_bank_ba #(.NUM_REGS(12)) u_d12 (
    .clock(clock), .clear(clear), .wr_en(wr_en), .wr_sel(wr_sel), .BusMuxOut(BusMuxOut),
    .rd_en(rd_en), .rd_sel(rd_sel), .BAout(BAout), .rsv_en(rsv_en), .rsv_sel(rsv_sel),
    .BusMuxIn(data_12), .rd_stall(stall_12), .pend_cnt(cnt_12), .rsv_err(err_12));

  initial clock = 1'b1;
  always #5 clock = ~clock;

  // Advance through one falling edge and settle just after it.
  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; rsv_en = 1'b0;
  endtask

  task automatic test_reset();
    rd_en = 1'b1; rd_sel = 4'd5; wr_en = 1'b1; wr_sel = 4'd5; BusMuxOut = 32'hFFFF_FFFF;
    step();
    checks++; if (data_m !== 32'h0) begin failures++; $display("FAIL reset_data got=%h exp=%h", data_m, 32'h0); end
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b exp=0", stall_m); end
    checks++; if (cnt_m !== 5'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", cnt_m); end
    checks++; if (err_m !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_m); end
    idle();
    clear = 1'b1;
    #1;
  endtask

  task automatic test_write();
    rd_en = 1'b1; rd_sel = 4'd5;
    wr_en = 1'b1; wr_sel = 4'd5; BusMuxOut = 32'hDEAD_BEEF;
    #1;
    checks++; if (data_m !== 32'h0) begin failures++; $display("FAIL write_before got=%h exp=%h", data_m, 32'h0); end
    @(posedge clock); #1;
    checks++; if (data_m !== 32'h0) begin failures++; $display("FAIL write_rise got=%h exp=%h", data_m, 32'h0); end
    step();
    idle();
    checks++; if (data_m !== 32'hDEAD_BEEF) begin failures++; $display("FAIL write_after got=%h exp=%h", data_m, 32'hDEAD_BEEF); end
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL write_stall got=%b exp=0", stall_m); end
  endtask

  task automatic test_ba_gate();
    wr_en = 1'b1; wr_sel = 4'd0; BusMuxOut = 32'h1234_5678;
    step();
    idle();
    rd_en = 1'b1; rd_sel = 4'd0; BAout = 1'b1;
    #1;
    checks++; if (data_m !== 32'h0) begin failures++; $display("FAIL ba1_gated got=%h exp=%h", data_m, 32'h0); end
    checks++; if (data_n !== 32'h1234_5678) begin failures++; $display("FAIL ba1_ungated got=%h exp=%h", data_n, 32'h1234_5678); end
    BAout = 1'b0;
    #1;
    checks++; if (data_m !== 32'h1234_5678) begin failures++; $display("FAIL ba0_gated got=%h exp=%h", data_m, 32'h1234_5678); end
    checks++; if (data_n !== 32'h1234_5678) begin failures++; $display("FAIL ba0_ungated got=%h exp=%h", data_n, 32'h1234_5678); end
    rd_en = 1'b0;
    #1;
    checks++; if (data_m !== 32'h0) begin failures++; $display("FAIL rd_en_off got=%h exp=%h", data_m, 32'h0); end
  endtask

  task automatic test_reserve();
    rsv_en = 1'b1; rsv_sel = 4'd3;
    step();
    idle();
    rd_en = 1'b1; rd_sel = 4'd3;
    #1;
    checks++; if (cnt_m !== 5'd1) begin failures++; $display("FAIL rsv_cnt got=%0d exp=1", cnt_m); end
    checks++; if (stall_m !== 1'b1) begin failures++; $display("FAIL rsv_stall got=%b exp=1", stall_m); end
    checks++; if (data_m !== 32'h0) begin failures++; $display("FAIL rsv_data got=%h exp=%h", data_m, 32'h0); end
    wr_en = 1'b1; wr_sel = 4'd3; BusMuxOut = 32'hA5A5_A5A5;
    step();
    idle();
    checks++; if (cnt_m !== 5'd0) begin failures++; $display("FAIL fill_cnt got=%0d exp=0", cnt_m); end
    checks++; if (data_m !== 32'hA5A5_A5A5) begin failures++; $display("FAIL fill_data got=%h exp=%h", data_m, 32'hA5A5_A5A5); end
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL fill_stall got=%b exp=0", stall_m); end
  endtask

  task automatic test_double_reserve();
    rsv_en = 1'b1; rsv_sel = 4'd7;
    step();
    checks++; if (err_m !== 1'b0) begin failures++; $display("FAIL rsv_once_err got=%b exp=0", err_m); end
    step();
    idle();
    checks++; if (err_m !== 1'b1) begin failures++; $display("FAIL rsv_twice_err got=%b exp=1", err_m); end
    checks++; if (cnt_m !== 5'd1) begin failures++; $display("FAIL rsv_twice_cnt got=%0d exp=1", cnt_m); end
    wr_en = 1'b1; wr_sel = 4'd7; BusMuxOut = 32'h7777_0007;
    step();
    idle();
    checks++; if (cnt_m !== 5'd0) begin failures++; $display("FAIL r7_fill_cnt got=%0d exp=0", cnt_m); end
    checks++; if (err_m !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_m); end
  endtask

  task automatic test_same_edge();
    wr_en = 1'b1; wr_sel = 4'd2; BusMuxOut = 32'h0F0F_0F0F;
    rsv_en = 1'b1; rsv_sel = 4'd2;
    rd_en = 1'b1; rd_sel = 4'd2;
    step();
    idle();
    checks++; if (cnt_m !== 5'd1) begin failures++; $display("FAIL same_cnt got=%0d exp=1", cnt_m); end
    checks++; if (stall_m !== 1'b1) begin failures++; $display("FAIL same_stall got=%b exp=1", stall_m); end
    checks++; if (data_m !== 32'h0) begin failures++; $display("FAIL same_data got=%h exp=%h", data_m, 32'h0); end
    wr_en = 1'b1; wr_sel = 4'd2; BusMuxOut = 32'h1111_1111;
    step();
    idle();
    checks++; if (data_m !== 32'h1111_1111) begin failures++; $display("FAIL same_refill got=%h exp=%h", data_m, 32'h1111_1111); end
    checks++; if (cnt_m !== 5'd0) begin failures++; $display("FAIL same_refill_cnt got=%0d exp=0", cnt_m); end
  endtask

  task automatic test_back_to_back();
    wr_en = 1'b1; wr_sel = 4'd6; BusMuxOut = 32'h0000_600D;
    rsv_en = 1'b1; rsv_sel = 4'd8;
    step();
    idle();
    rd_en = 1'b1; rd_sel = 4'd6;
    #1;
    checks++; if (data_m !== 32'h0000_600D) begin failures++; $display("FAIL b2b_r6 got=%h exp=%h", data_m, 32'h0000_600D); end
    checks++; if (cnt_m !== 5'd1) begin failures++; $display("FAIL b2b_cnt got=%0d exp=1", cnt_m); end
    rd_sel = 4'd8;
    #1;
    checks++; if (stall_m !== 1'b1) begin failures++; $display("FAIL b2b_r8_stall got=%b exp=1", stall_m); end
    wr_en = 1'b1; wr_sel = 4'd8; BusMuxOut = 32'h0000_0808;
    step();
    idle();
    checks++; if (data_m !== 32'h0000_0808) begin failures++; $display("FAIL b2b_r8 got=%h exp=%h", data_m, 32'h0000_0808); end
  endtask

  task automatic test_out_of_range();
    wr_en = 1'b1; wr_sel = 4'd13; BusMuxOut = 32'hBAD0_BAD0;
    rsv_en = 1'b1; rsv_sel = 4'd13;
    rd_en = 1'b1; rd_sel = 4'd13;
    step();
    idle();
    checks++; if (cnt_12 !== 5'd0) begin failures++; $display("FAIL oor_cnt12 got=%0d exp=0", cnt_12); end
    checks++; if (data_12 !== 32'h0) begin failures++; $display("FAIL oor_data12 got=%h exp=%h", data_12, 32'h0); end
    checks++; if (stall_12 !== 1'b0) begin failures++; $display("FAIL oor_stall12 got=%b exp=0", stall_12); end
    checks++; if (cnt_m !== 5'd1) begin failures++; $display("FAIL r13_cnt16 got=%0d exp=1", cnt_m); end
    checks++; if (stall_m !== 1'b1) begin failures++; $display("FAIL r13_stall16 got=%b exp=1", stall_m); end
    wr_en = 1'b1; wr_sel = 4'd13; BusMuxOut = 32'h0000_0013;
    step();
    idle();
    checks++; if (data_m !== 32'h0000_0013) begin failures++; $display("FAIL r13_fill16 got=%h exp=%h", data_m, 32'h0000_0013); end
  endtask

  task automatic test_clear();
    rsv_en = 1'b1; rsv_sel = 4'd1; step();
    rsv_sel = 4'd4; step();
    rsv_sel = 4'd9; step();
    idle();
    checks++; if (cnt_m !== 5'd3) begin failures++; $display("FAIL pre_clear_cnt got=%0d exp=3", cnt_m); end
    rd_en = 1'b1; rd_sel = 4'd4;
    #2;
    clear = 1'b0;
    #1;
    checks++; if (cnt_m !== 5'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", cnt_m); end
    checks++; if (err_m !== 1'b0) begin failures++; $display("FAIL clr_err got=%b exp=0", err_m); end
    checks++; if (stall_m !== 1'b0) begin failures++; $display("FAIL clr_stall got=%b exp=0", stall_m); end
    #1;
    clear = 1'b1;
    for (int i = 0; i < 16; i++) begin
      rd_sel = 4'(i);
      #1;
      checks++; if (data_m !== 32'h0 || stall_m !== 1'b0) begin
        failures++; $display("FAIL clr_read_r%0d got=%h/%b exp=%h/0", i, data_m, stall_m, 32'h0);
      end
    end
  endtask

  initial begin
    clear = 1'b0; wr_en = 1'b0; rd_en = 1'b0; BAout = 1'b0; rsv_en = 1'b0;
    wr_sel = '0; rd_sel = '0; rsv_sel = '0; BusMuxOut = '0;
    #2;
    test_reset();
    test_write();
    test_ba_gate();
    test_reserve();
    test_double_reserve();
    test_same_edge();
    test_back_to_back();
    test_out_of_range();
    test_clear();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/register_bank_ba.md
Name: register_bank_ba

Overview:
- Parametrised general-purpose register bank that supersedes the individual per-register modules on the datapath.
- Holds NUM_REGS registers, each WIDTH bits wide. It is written from BusMuxOut and drives a single read value onto BusMuxIn.
- Register 0 reads as zero while BAout is asserted, which gives base-address arithmetic a zero base.
- Adds a per-register pending scoreboard for multi-cycle loads: read stall, pending count and a sticky double-reserve error.

Parameters:
- WIDTH, 32, data width of every register and of both bus ports.
- NUM_REGS, 16, number of registers; legal range 2..2**SEL_W.
- SEL_W, 4, width of the register-select fields.
- R0_BA_GATE, 1, 1 = register 0 reads zero when BAout=1; 0 = register 0 behaves as an ordinary register.

Ports:
- clock  in  1  bank clock; all state updates on the falling edge.
- clear  in  1  asynchronous, active-low reset.
- wr_en  in  1  write strobe (Rin).
- wr_sel  in  SEL_W  register to write.
- BusMuxOut  in  WIDTH  write data from the bus.
- rd_en  in  1  read strobe (Rout).
- rd_sel  in  SEL_W  register to read.
- BAout  in  1  base-address mode; forces register 0 to read as zero.
- rsv_en  in  1  reserve strobe; marks a register pending for an outstanding load.
- rsv_sel  in  SEL_W  register to reserve.
- BusMuxIn  out  WIDTH  read data (combinational).
- rd_stall  out  1  read targets a pending register (combinational).
- pend_cnt  out  SEL_W+1  number of registers currently pending (registered).
- rsv_err  out  1  sticky flag: a reserve hit a register that was already pending.

Behaviour:
- Reset (clear=0, asynchronous):
  - all regs = 0; all valid bits = 1; pend_cnt = 0; rsv_err = 0.
  - BusMuxIn = 0 and rd_stall = 0 while clear=0, regardless of other inputs.
- State update happens on the falling edge of clock only. Rising edges have no effect.
- Write (wr_en=1, wr_sel < NUM_REGS):
  - regs[wr_sel] <= BusMuxOut; valid[wr_sel] <= 1.
  - wr_sel >= NUM_REGS: the write is ignored; no state changes.
- Reserve (rsv_en=1, rsv_sel < NUM_REGS):
  - valid[rsv_sel] <= 0.
  - If valid[rsv_sel] was already 0, rsv_err <= 1. rsv_err stays 1 until clear.
  - Out-of-range rsv_sel is ignored.
- Write and reserve on the same register in the same edge:
  - the data is written and valid ends at 0 (reserve wins);
  - rsv_err follows the valid value from before the edge.
- Write and reserve on different registers in the same edge: both take effect independently.
- pend_cnt:
  - registered; equals the number of valid bits that are 0 after the edge;
  - updated in the same edge as the valid bits;
  - never exceeds NUM_REGS and never goes negative.
  - Writing a register that is already valid does not change the count. Re-reserving a pending register does not change the count.
- Read data (combinational):
  - BusMuxIn = 0 when any of: rd_en=0; rd_sel >= NUM_REGS; (R0_BA_GATE=1 && rd_sel=0 && BAout=1); rd_stall=1.
  - Otherwise BusMuxIn = regs[rd_sel].
- rd_stall = rd_en && rd_sel < NUM_REGS && !valid[rd_sel] && !(R0_BA_GATE && rd_sel=0 && BAout).
- Read latency:
  - A write becomes visible on BusMuxIn immediately after the falling edge that captures it. There is no same-cycle bypass.
  - A read before that edge returns the old value, or stalls if the register is pending.
- BAout gating applies only to the read path. Writes to register 0 always store, so R0 reads back its value once BAout=0.
- Reset mid-operation:
  - asserting clear immediately discards all pending reservations and data;
  - rsv_err clears;
  - there is no dependence on clock.

Test Plan:
- Reset, then write 0xDEADBEEF to R5 on one falling edge -> R5 reads 0 before the edge and 0xDEADBEEF after it; rd_stall=0.
- Write 0x12345678 to R0, then read R0 -> BAout=1 gives 0x00000000; BAout=0 gives 0x12345678. With R0_BA_GATE=0, both give 0x12345678.
- Reserve R3 -> pend_cnt=1; a read of R3 gives rd_stall=1 and BusMuxIn=0. Write 0xA5A5A5A5 to R3 -> pend_cnt=0; the read gives 0xA5A5A5A5 with no stall.
- Reserve R7 twice -> rsv_err=1 and pend_cnt=1. A write to R7 clears the pending bit but rsv_err stays 1 until clear=0.
- Write and reserve R2 in the same edge with 0x0F0F0F0F -> R2 is pending and pend_cnt increments. A later write of 0x11111111 gives a read of 0x11111111.
- Reserve R1, R4 and R9 (pend_cnt=3), then pulse clear low asynchronously mid-cycle -> pend_cnt=0, all registers read 0, rsv_err=0. With NUM_REGS=12, wr_sel=13 is ignored and rd_sel=13 reads 0 with no stall.
